// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, constants, reset PC.
// Counter width applies only when FETCH_PERF_CNT_EN is defined.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          CNT_W            = 16;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating event counter used by the fetch stage performance monitors.
// Compiled only when FETCH_PERF_CNT_EN is defined.
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_cnt
    import fetch_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`endif

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and stall/flush FSM.
// Optional stall/bubble performance counters are enabled with FETCH_PERF_CNT_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic [31:0] if_id_ins,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [1:0]  fetch_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] bubble_cycles
`endif
);

    fetch_state_e r_state;
    fetch_state_e w_next_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_if_id_ins;
    logic [31:0]  r_if_id_pc4;
    logic         r_if_id_valid;
    logic [31:0]  w_pc_plus4;

    assign w_pc_plus4 = r_pc + PC_STEP;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default assignment first so no path through the block can infer a latch.
    always_comb begin
        w_next_state = ST_FETCH;
        if (redirect) begin
            w_next_state = ST_FLUSH;
        end else if (stall) begin
            w_next_state = ST_HOLD;
        end
    end

    // Encoding 3 is never entered, but is reported as FETCH should it ever appear.
    always_comb begin
        fetch_state = ST_FETCH;
        case (r_state)
            ST_HOLD:  fetch_state = ST_HOLD;
            ST_FLUSH: fetch_state = ST_FLUSH;
            default:  fetch_state = ST_FETCH;
        endcase
    end

    // Redirect wins over stall; the word fetched at the old PC is discarded as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_if_id_ins   <= NOP_INSTR;
            r_if_id_pc4   <= '0;
            r_if_id_valid <= 1'b0;
        end else if (redirect) begin
            r_pc          <= {redirect_pc[31:2], 2'b00};
            r_if_id_ins   <= NOP_INSTR;
            r_if_id_pc4   <= '0;
            r_if_id_valid <= 1'b0;
        end else if (!stall) begin
            r_pc          <= w_pc_plus4;
            r_if_id_ins   <= imem_rdata;
            r_if_id_pc4   <= w_pc_plus4;
            r_if_id_valid <= 1'b1;
        end
    end

    assign imem_addr   = r_pc;
    assign ins         = imem_rdata;
    assign if_id_ins   = r_if_id_ins;
    assign if_id_pc4   = r_if_id_pc4;
    assign if_id_valid = r_if_id_valid;

`ifdef FETCH_PERF_CNT_EN
    logic w_stall_evt;

    assign w_stall_evt = stall && !redirect;

    fetch_perf_cnt u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_stall_evt),
        .o_count (stall_cycles)
    );

    fetch_perf_cnt u_bubble_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (redirect),
        .o_count (bubble_cycles)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle model compare plus literal checkpoints.
// Define FETCH_PERF_CNT_EN to also exercise the performance counters.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ins;
    logic [31:0] if_id_ins;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [1:0]  fetch_state;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] bubble_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .ins         (ins),
        .if_id_ins   (if_id_ins),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .fetch_state (fetch_state)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles  (stall_cycles),
        .bubble_cycles (bubble_cycles)
`endif
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A00;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural effect of each edge, straight from the priority rules.
    logic [31:0] m_pc, m_ins, m_pc4;
    logic        m_valid;
    int          m_state;
    int          m_stall_cnt, m_bubble_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h0; m_ins = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_state = 0;
            m_stall_cnt = 0; m_bubble_cnt = 0;
        end else if (redirect) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            m_ins = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_state = 2;
            if (m_bubble_cnt < 65535) m_bubble_cnt++;
        end else if (stall) begin
            m_state = 1;
            if (m_stall_cnt < 65535) m_stall_cnt++;
        end else begin
            m_ins = mem_word(m_pc);
            m_pc = m_pc + 32'd4;
            m_pc4 = m_pc;
            m_valid = 1'b1;
            m_state = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("imem_addr", imem_addr, m_pc);
            check("ins", ins, mem_word(m_pc));
            check("if_id_ins", if_id_ins, m_ins);
            check("if_id_pc4", if_id_pc4, m_pc4);
            check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
            check("fetch_state", {30'd0, fetch_state}, m_state);
`ifdef FETCH_PERF_CNT_EN
            check("stall_cycles", {16'd0, stall_cycles}, m_stall_cnt);
            check("bubble_cycles", {16'd0, bubble_cycles}, m_bubble_cnt);
`endif
        end
    end

    task automatic step(input logic s, input logic r, input logic [31:0] t);
        stall = s; redirect = r; redirect_pc = t;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_addr", imem_addr, 32'h0);
        check("rst_ins", if_id_ins, 32'h0);
        check("rst_pc4", if_id_pc4, 32'h0);
        check("rst_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_state", {30'd0, fetch_state}, 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Four plain advances from reset.
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 32'h0);
            check("adv_addr", imem_addr, 32'(4 * i));
            check("adv_pc4", if_id_pc4, 32'(4 * i));
            check("adv_valid", {31'd0, if_id_valid}, 32'd1);
        end

        // Three-cycle stall at pc 0x10 holds everything.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0);
            check("hold_addr", imem_addr, 32'h10);
            check("hold_ins", if_id_ins, mem_word(32'hC));
            check("hold_state", {30'd0, fetch_state}, 32'd1);
        end
        step(1'b0, 1'b0, 32'h0);
        check("rel_addr", imem_addr, 32'h14);
        check("rel_state", {30'd0, fetch_state}, 32'd0);
        check("rel_ins", if_id_ins, mem_word(32'h10));

        // Redirect beats stall; target is word-aligned.
        step(1'b1, 1'b1, 32'h0000_0103);
        check("redir_addr", imem_addr, 32'h100);
        check("redir_ins", if_id_ins, 32'h0);
        check("redir_valid", {31'd0, if_id_valid}, 32'd0);
        check("redir_state", {30'd0, fetch_state}, 32'd2);

        // Back-to-back redirects each land.
        step(1'b0, 1'b1, 32'h0000_0200);
        check("redir2_addr", imem_addr, 32'h200);
        step(1'b1, 1'b1, 32'h0000_0307);
        check("redir3_addr", imem_addr, 32'h304);
        check("redir3_state", {30'd0, fetch_state}, 32'd2);
        step(1'b0, 1'b0, 32'h0);
        check("post_redir_ins", if_id_ins, mem_word(32'h304));
        check("post_redir_valid", {31'd0, if_id_valid}, 32'd1);

        // PC wraps at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFE);
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc4", if_id_pc4, 32'h0);

        // Asynchronous reset in the middle of a hold.
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check("pre_rst_state", {30'd0, fetch_state}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_addr", imem_addr, 32'h0);
        check("arst_ins", if_id_ins, 32'h0);
        check("arst_valid", {31'd0, if_id_valid}, 32'd0);
        check("arst_state", {30'd0, fetch_state}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(1'b1, 1'b0, 32'h0);
        check("after_rst_hold", {30'd0, fetch_state}, 32'd1);
        step(1'b0, 1'b0, 32'h0);
        check("after_rst_addr", imem_addr, 32'h4);

`ifdef FETCH_PERF_CNT_EN
        // Counter saturation and bubble counting from a clean reset.
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        for (int i = 0; i < 70000; i++) step(1'b1, 1'b0, 32'h0);
        check("stall_sat", {16'd0, stall_cycles}, 32'h0000_FFFF);
        step(1'b0, 1'b1, 32'h40);
        step(1'b0, 1'b1, 32'h80);
        check("bubble_cnt", {16'd0, bubble_cycles}, 32'd2);
        check("stall_sat_hold", {16'd0, stall_cycles}, 32'h0000_FFFF);
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, shall be the PC value loaded on reset.
REQ-002 clk  input  1  shall be the single rising-edge clock for all state.
REQ-003 rst_n  input  1  shall be the asynchronous, active-low reset.
REQ-004 stall  input  1  shall be the hazard-control stall request: hold PC and IF/ID.
REQ-005 redirect  input  1  shall be the taken branch/jump indication from the resolving stage.
REQ-006 redirect_pc  input  32  shall be the branch/jump target address.
REQ-007 imem_addr  output  32  shall be the instruction-memory address, equal to the current PC.
REQ-008 imem_rdata  input  32  shall be the instruction word, read combinationally in the same cycle.
REQ-009 ins  output  32  shall be the fetched word forwarded to hazard control, equal to imem_rdata.
REQ-010 if_id_ins  output  32  shall be the registered IF/ID instruction.
REQ-011 if_id_pc4  output  32  shall be the registered PC+4 of if_id_ins.
REQ-012 if_id_valid  output  1  shall be high when if_id_ins is a real instruction, not a bubble.
REQ-013 fetch_state  output  2  shall be the current FSM state: FETCH=0, HOLD=1, FLUSH=2.

Function
REQ-014 Priority shall be redirect > stall > normal advance, evaluated every rising edge.
REQ-015 Normal advance shall update the registers as: pc <= pc+4, mod 2^32, wrapping 32'hFFFF_FFFC to 0; if_id_ins <= imem_rdata; if_id_pc4 <= pc+4; if_id_valid <= 1.
REQ-016 Stall without redirect shall hold pc, if_id_ins, if_id_pc4 and if_id_valid unchanged.
REQ-017 Redirect shall update the registers as: pc <= {redirect_pc[31:2],2'b00}; if_id_ins <= 32'h0 (NOP); if_id_pc4 <= 0; if_id_valid <= 0.
REQ-018 Redirect asserted together with stall shall behave exactly as redirect alone.
REQ-019 The FSM shall transition as follows:
- FETCH: redirect->FLUSH; stall->HOLD; else FETCH.
- HOLD: redirect->FLUSH; stall->HOLD; else FETCH.
- FLUSH: redirect->FLUSH; stall->HOLD; else FETCH.
REQ-020 Latency from imem_rdata to if_id_ins shall be one cycle; from redirect to imem_addr==target, one cycle.
REQ-021 Consecutive redirects shall each reload pc and keep inserting bubbles, with no lost target.
REQ-022 The unused state encoding 3 shall recover to FETCH on the next edge, with no output corruption.

Reset
REQ-023 While rst_n is low, pc shall be RESET_PC, if_id_ins=0, if_id_pc4=0, if_id_valid=0, fetch_state=FETCH, and all counters 0, asynchronously.
REQ-024 On the first edge after rst_n deasserts, normal priority rules shall apply; reset shall abort a stall or flush in progress.

Configuration
REQ-025 Macro FETCH_PERF_CNT_EN shall control the performance counters.
- Defined: add outputs stall_cycles[15:0] and bubble_cycles[15:0].
- stall_cycles shall increment each edge with stall=1 and redirect=0.
- bubble_cycles shall increment on each redirect edge.
- Both counters shall saturate at 16'hFFFF.
- Undefined: the ports and logic shall be absent, with all other behaviour identical.

Structure
REQ-026 A shared package shall hold the FSM state typedef and encodings, NOP_INSTR=32'h0, PC_STEP=4, and the default RESET_PC.
REQ-027 One sub-module, fetch_perf_cnt (saturating 16-bit counter, instantiated twice), shall exist only under FETCH_PERF_CNT_EN.

Verification
REQ-028 Reset release with RESET_PC=0 and no stall for 4 cycles -> imem_addr 0,4,8,C; if_id_pc4 4,8,C,10; if_id_valid=1 from cycle 1.
REQ-029 stall=1 for 3 cycles at pc=0x10 -> imem_addr stays 0x10, if_id_ins unchanged, fetch_state=HOLD; on release -> pc=0x14, state FETCH.
REQ-030 redirect=1, redirect_pc=0x0000_0103 while stall=1 -> next cycle pc=0x100, if_id_ins=0, if_id_valid=0, state FLUSH.
REQ-031 pc=0xFFFF_FFFC with normal advance -> pc=0, if_id_pc4=0.
REQ-032 rst_n pulsed low mid-HOLD -> outputs immediately take reset values, state FETCH, without waiting for an edge.
REQ-033 With FETCH_PERF_CNT_EN defined, 70000 stall cycles then 2 redirects -> stall_cycles=16'hFFFF, bubble_cycles=2.
